hit_arbiter: RTL and testbench

Round-robin controller that serializes per-ball border-collision events into the single velocity write port of the ball state registers in the HIT_CONTROLLER. Each ball's collision detector pulses a request together with its reflected velocity for that cycle. The arbiter captures the pulse and velocity, then offers the updates one at a time over a valid/ready handshake. It limits each ball to one velocity update per video frame, so a ball that overlaps a border for several cycles is reflected only once.

---
 rtl/hit_arbiter_if.sv | 17 +
 rtl/hit_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_hit_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hit_arbiter_if.sv
// Velocity-update handshake between hit_arbiter (master) and the ball state
// register write port (slave).
interface hit_arbiter_if #(
  parameter int NUM_BALLS = 4,
  parameter int VEL_W     = 11
);
  localparam int ID_W = $clog2(NUM_BALLS);

  logic                    updValid;
  logic                    updReady;
  logic [ID_W-1:0]         updBallId;
  logic signed [VEL_W-1:0] updVelX;
  logic signed [VEL_W-1:0] updVelY;

  modport master (output updValid, updBallId, updVelX, updVelY, input  updReady);
  modport slave  (input  updValid, updBallId, updVelX, updVelY, output updReady);
endinterface

// File: rtl/hit_arbiter.sv
// hit_arbiter: round-robin serializer of per-ball collision velocity updates,
// one update per ball per frame. HIT_ARB_STATS_EN adds hitCount_o/dropCount_o.

module hit_arbiter_lane #(
  parameter int VEL_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof_i,
  input  logic             req_i,
  input  logic             grant_i,
  input  logic [VEL_W-1:0] velX_i,
  input  logic [VEL_W-1:0] velY_i,
  output logic             pending_o,
`ifdef HIT_ARB_STATS_EN
  output logic             drop_o,
`endif
  output logic [VEL_W-1:0] velX_o,
  output logic [VEL_W-1:0] velY_o
);
  logic             pending_q, served_q, capture;
  logic [VEL_W-1:0] velX_q, velY_q;

  // Frame start re-arms a served ball in the same cycle it pulses.
  assign capture = req_i && !pending_q && (!served_q || sof_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      served_q  <= 1'b0;
      velX_q    <= '0;
      velY_q    <= '0;
    end else begin
      if (capture) begin
        pending_q <= 1'b1;
        velX_q    <= velX_i;
        velY_q    <= velY_i;
      end else if (grant_i) begin
        pending_q <= 1'b0;
      end
      // A grant coinciding with frame start still marks the ball served.
      if (grant_i)    served_q <= 1'b1;
      else if (sof_i) served_q <= 1'b0;
    end
  end

  assign pending_o = pending_q;
  assign velX_o    = velX_q;
  assign velY_o    = velY_q;
`ifdef HIT_ARB_STATS_EN
  assign drop_o    = req_i && !capture;
`endif
endmodule

module hit_arbiter #(
  parameter int NUM_BALLS = 4,
  parameter int VEL_W     = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame_i,
  input  logic [NUM_BALLS-1:0]       collisionReq_i,
  input  logic [NUM_BALLS*VEL_W-1:0] velXIn_i,
  input  logic [NUM_BALLS*VEL_W-1:0] velYIn_i,
  hit_arbiter_if.master              upd,
`ifdef HIT_ARB_STATS_EN
  output logic [7:0]                 hitCount_o,
  output logic [7:0]                 dropCount_o,
`endif
  output logic                       busy_o
);
  localparam int ID_W = $clog2(NUM_BALLS);

  typedef enum logic {IDLE, OFFER} state_e;
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [VEL_W-1:0] velX;
    logic [VEL_W-1:0] velY;
  } upd_t;

  state_e                             state_q;
  upd_t                               upd_q, sel;
  logic [ID_W-1:0]                    rrPtr_q;
  logic                               updValid_q, sel_found, accept;
  logic [NUM_BALLS-1:0]               pending, grant;
  logic [NUM_BALLS-1:0][VEL_W-1:0]    capX, capY;
  int                                 idx;
`ifdef HIT_ARB_STATS_EN
  logic [NUM_BALLS-1:0]               drop;
`endif

  assign accept = updValid_q && upd.updReady;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_lane
    assign grant[g] = accept && (upd_q.id == ID_W'(g));
    hit_arbiter_lane #(.VEL_W(VEL_W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .sof_i     (startOfFrame_i),
      .req_i     (collisionReq_i[g]),
      .grant_i   (grant[g]),
      .velX_i    (velXIn_i[g*VEL_W +: VEL_W]),
      .velY_i    (velYIn_i[g*VEL_W +: VEL_W]),
      .pending_o (pending[g]),
`ifdef HIT_ARB_STATS_EN
      .drop_o    (drop[g]),
`endif
      .velX_o    (capX[g]),
      .velY_o    (capY[g])
    );
  end

  // Scan downward so the candidate nearest rrPtr (smallest offset) wins.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    idx       = 0;
    for (int k = NUM_BALLS-1; k >= 0; k--) begin
      idx = (int'(rrPtr_q) + k) % NUM_BALLS;
      if (pending[idx]) begin
        sel_found = 1'b1;
        sel.id    = ID_W'(idx);
        sel.velX  = capX[idx];
        sel.velY  = capY[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      updValid_q <= 1'b0;
      upd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (sel_found) begin
          upd_q      <= sel;
          updValid_q <= 1'b1;
          state_q    <= OFFER;
        end
        OFFER: if (upd.updReady) begin
          updValid_q <= 1'b0;
          rrPtr_q    <= (upd_q.id == ID_W'(NUM_BALLS-1)) ? '0 : ID_W'(upd_q.id + 1'b1);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign upd.updValid  = updValid_q;
  assign upd.updBallId = upd_q.id;
  assign upd.updVelX   = upd_q.velX;
  assign upd.updVelY   = upd_q.velY;
  assign busy_o        = (|pending) || updValid_q;

`ifdef HIT_ARB_STATS_EN
  logic [7:0] hitCount_q, dropCount_q, dropCount_d;
  int         dropSum;

  always_comb begin
    dropSum = int'(dropCount_q);
    for (int i = 0; i < NUM_BALLS; i++) dropSum = dropSum + int'(drop[i]);
    dropCount_d = (dropSum > 255) ? 8'hFF : 8'(dropSum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hitCount_q  <= '0;
      dropCount_q <= '0;
    end else begin
      if (accept && hitCount_q != 8'hFF) hitCount_q <= hitCount_q + 8'd1;
      dropCount_q <= dropCount_d;
    end
  end

  assign hitCount_o  = hitCount_q;
  assign dropCount_o = dropCount_q;
`endif
endmodule

// File: tb/tb_hit_arbiter.sv
// Randomized + directed bench for hit_arbiter against a per-frame behavioural model.
module tb_hit_arbiter;
  localparam int N = 4;
  localparam int W = 11;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sof = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][W-1:0] vx_arr = '0;
  logic [N-1:0][W-1:0] vy_arr = '0;
  logic                busy;
  int                  n_cmp = 0;
  int                  n_bad = 0;
  bit                  chk_en = 1'b0;
`ifdef HIT_ARB_STATS_EN
  logic [7:0]          hitCount, dropCount;
`endif

  hit_arbiter_if #(.NUM_BALLS(N), .VEL_W(W)) u_if ();

  hit_arbiter #(.NUM_BALLS(N), .VEL_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame_i (sof),
    .collisionReq_i (req),
    .velXIn_i       (vx_arr),
    .velYIn_i       (vy_arr),
    .upd            (u_if),
`ifdef HIT_ARB_STATS_EN
    .hitCount_o     (hitCount),
    .dropCount_o    (dropCount),
`endif
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each ball is either free, waiting, or done for this frame; the port
  // offers one waiting ball at a time, picking round-robin after the last one served.
  bit pend[N], serv[N];
  int cx[N], cy[N];
  bit m_valid;
  int m_id, m_vx, m_vy, rr, m_hit, m_drop;

  always @(posedge clk) begin : model
    bit old_pend[N];
    bit acc;
    int nd, j;
    if (reset) begin
      for (int i = 0; i < N; i++) begin pend[i] = 0; serv[i] = 0; cx[i] = 0; cy[i] = 0; end
      m_valid = 0; m_id = 0; m_vx = 0; m_vy = 0; rr = 0; m_hit = 0; m_drop = 0;
    end else begin
      old_pend = pend;
      acc = m_valid && u_if.updReady;
      nd = 0;
      for (int i = 0; i < N; i++)
        if (req[i]) begin
          if (!pend[i] && (!serv[i] || sof)) begin
            pend[i] = 1; cx[i] = $signed(vx_arr[i]); cy[i] = $signed(vy_arr[i]);
          end else nd++;
        end
      if (sof) for (int i = 0; i < N; i++) serv[i] = 0;
      if (acc) begin
        pend[m_id] = 0; serv[m_id] = 1; rr = (m_id + 1) % N; m_valid = 0;
        if (m_hit < 255) m_hit++;
      end else if (!m_valid) begin
        for (int k = 0; k < N && !m_valid; k++) begin
          j = (rr + k) % N;
          if (old_pend[j]) begin m_valid = 1; m_id = j; m_vx = cx[j]; m_vy = cy[j]; end
        end
      end
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    end
  end

  function automatic bit model_busy();
    bit b = m_valid;
    for (int i = 0; i < N; i++) b |= pend[i];
    return b;
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("valid", u_if.updValid, m_valid);
    chk("busy", busy, model_busy());
    if (m_valid) begin
      chk("id", u_if.updBallId, m_id);
      chk("velX", u_if.updVelX, m_vx);
      chk("velY", u_if.updVelY, m_vy);
    end
`ifdef HIT_ARB_STATS_EN
    chk("hitCount", hitCount, m_hit);
    chk("dropCount", dropCount, m_drop);
`endif
  end

  int log_id[$], log_vx[$];
  always @(posedge clk) if (!reset && u_if.updValid && u_if.updReady) begin
    log_id.push_back(int'(u_if.updBallId));
    log_vx.push_back(int'(u_if.updVelX));
  end

  task automatic tick(); @(negedge clk); endtask
  task automatic do_reset();
    reset = 1; req = '0; sof = 0; tick(); reset = 0;
  endtask
  task automatic set_vel(input int b, input int x, input int y);
    vx_arr[b] = W'(x); vy_arr[b] = W'(y);
  endtask
  task automatic exp_offer(input string nm, input int id);
    chk({nm, ".valid"}, u_if.updValid, 1);
    chk({nm, ".id"}, u_if.updBallId, id);
  endtask

  initial begin
    u_if.updReady = 1'b1;
    tick();
    chk_en = 1'b1;

    // Single request, latency and reset values
    do_reset();
    chk("rst.valid", u_if.updValid, 0); chk("rst.id", u_if.updBallId, 0);
    chk("rst.velX", u_if.updVelX, 0);   chk("rst.busy", busy, 0);
    req = 4'b0010; set_vel(1, 5, -3); tick(); req = '0;
    chk("s1.busy", busy, 1); chk("s1.early", u_if.updValid, 0);
    tick();
    exp_offer("s1", 1); chk("s1.velX", u_if.updVelX, 5); chk("s1.velY", u_if.updVelY, -3);
    tick();
    chk("s1.drop", u_if.updValid, 0); chk("s1.idle", busy, 0);

    // Round-robin order and pointer wrap
    do_reset();
    req = 4'b1011; tick(); req = '0; tick();
    exp_offer("s2a", 0); tick(); chk("s2.gap", u_if.updValid, 0); tick();
    exp_offer("s2b", 1); tick(); tick();
    exp_offer("s2c", 3); tick(); chk("s2.done", busy, 0);
    sof = 1; tick(); sof = 0;
    req = 4'b1001; tick(); req = '0; tick();
    exp_offer("s2d", 0); tick(); tick();
    exp_offer("s2e", 3); tick();

    // Once-per-frame suppression
    do_reset();
    log_id.delete(); log_vx.delete();
    for (int c = 0; c < 5; c++) begin req = 4'b0100; set_vel(2, 10 + c, 1); tick(); end
    req = '0; repeat (4) tick();
    chk("s3.n1", log_id.size(), 1);
    if (log_id.size() >= 1) begin chk("s3.id", log_id[0], 2); chk("s3.vx", log_vx[0], 10); end
    sof = 1; tick(); sof = 0;
    req = 4'b0100; set_vel(2, 20, 1); tick(); req = '0; repeat (3) tick();
    chk("s3.n2", log_id.size(), 2);
    if (log_id.size() >= 2) chk("s3.vx2", log_vx[1], 20);
`ifdef HIT_ARB_STATS_EN
    chk("s3.hit", hitCount, 2); chk("s3.dropc", dropCount, 4);
`endif

    // Back-pressure hold
    do_reset();
    u_if.updReady = 0;
    req = 4'b0001; set_vel(0, 7, 8); tick(); req = '0; tick();
    for (int c = 0; c < 10; c++) begin
      exp_offer("s4.hold", 0);
      chk("s4.vx", u_if.updVelX, 7); chk("s4.vy", u_if.updVelY, 8);
      if (c == 3) begin req = 4'b1000; set_vel(3, -4, 2); end else req = '0;
      tick();
    end
    u_if.updReady = 1; tick(); tick();
    exp_offer("s4.next", 3); chk("s4.vx3", u_if.updVelX, -4); chk("s4.vy3", u_if.updVelY, 2);
    tick();

    // Frame start together with a served ball's pulse
    do_reset();
    log_id.delete(); log_vx.delete();
    req = 4'b0010; set_vel(1, 1, 1); tick(); req = '0; repeat (3) tick();
    sof = 1; req = 4'b0010; set_vel(1, 9, -9); tick(); sof = 0; req = '0; repeat (3) tick();
    chk("s5.n", log_id.size(), 2);
    if (log_id.size() >= 2) begin chk("s5.id", log_id[1], 1); chk("s5.vx", log_vx[1], 9); end

    // Reset during an offer
    do_reset();
    u_if.updReady = 0;
    req = 4'b1100; tick(); req = '0; tick();
    exp_offer("s6", 2);
    reset = 1; tick(); reset = 0;
    chk("s6.valid", u_if.updValid, 0); chk("s6.busy", busy, 0);
    u_if.updReady = 1; log_id.delete(); log_vx.delete();
    repeat (10) tick();
    chk("s6.none", log_id.size(), 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(799) == 0);
      sof = ($urandom_range(39) == 0);
      for (int i = 0; i < N; i++) begin
        req[i] = ($urandom_range(7) == 0);
        vx_arr[i] = W'($urandom); vy_arr[i] = W'($urandom);
      end
      u_if.updReady = ($urandom_range(3) != 0);
      tick();
    end
    reset = 0; req = '0; sof = 0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
